// File: rtl/stepper_axis_ctrl.sv
// N-axis step/dir pulse generator with per-axis register, jog override and pulse-timing FSM.
// Optional POSITION_EN macro adds a signed per-axis step position counter and the pos_out port.
//
// state | meaning
// IDLE  | no motion requested, step low
// SETUP | dir_out just changed, waiting DIR_SETUP_CYCLES before the next rising edge
// PULSE | step_out high for exactly PULSE_CYCLES clocks
// GAP   | step_out low, waiting for the period counter to reach the effective period
module stepper_axis_ctrl #(
    parameter int NUM_AXES         = 2,
    parameter int SPEED_W          = 32,
    parameter int PULSE_CYCLES     = 200,
    parameter int DIR_SETUP_CYCLES = 500,
    parameter int JOG_PERIOD       = 50000,
    parameter int POS_W            = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_AXES-1:0]         load,
    input  logic [NUM_AXES*SPEED_W-1:0] speed_in,
    input  logic [NUM_AXES-1:0]         dir_in,
    input  logic [NUM_AXES-1:0]         jog_pos,
    input  logic [NUM_AXES-1:0]         jog_neg,
    output logic [NUM_AXES-1:0]         step_out,
    output logic [NUM_AXES-1:0]         dir_out,
    output logic [NUM_AXES-1:0]         busy
`ifdef POSITION_EN
    ,
    output logic [NUM_AXES*POS_W-1:0]   pos_out
`endif
);

    localparam int TMR_MAX = (PULSE_CYCLES > DIR_SETUP_CYCLES) ? PULSE_CYCLES : DIR_SETUP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [SPEED_W-1:0] MIN_PERIOD = SPEED_W'(2 * PULSE_CYCLES);
    localparam logic [SPEED_W-1:0] JOG_P      = SPEED_W'(JOG_PERIOD);
    localparam logic [TMR_W-1:0]   PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0]   SETUP_LOAD = TMR_W'(DIR_SETUP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        logic [SPEED_W-1:0] reg_period;
        logic               reg_dir;
        logic [SPEED_W-1:0] eff_raw;
        logic [SPEED_W-1:0] eff_period;
        logic               eff_dir;
        state_t             state;
        state_t             state_nxt;
        logic [TMR_W-1:0]   tmr;
        logic [SPEED_W-1:0] pcnt;
        logic               dir_q;
        logic               dir_load;
        logic               rise;
        logic               step_o;
        logic               busy_o;

        always_ff @(posedge clock) begin
            if (!reset) begin
                reg_period <= '0;
                reg_dir    <= 1'b0;
            end else if (load[i]) begin
                reg_period <= speed_in[i*SPEED_W +: SPEED_W];
                reg_dir    <= dir_in[i];
            end
        end

        // Jog overrides the command without disturbing the stored register values.
        always_comb begin
            eff_raw = reg_period;
            eff_dir = reg_dir;
            if (jog_pos[i] ^ jog_neg[i]) begin
                eff_raw = JOG_P;
                eff_dir = jog_neg[i];
            end else if (jog_pos[i] & jog_neg[i]) begin
                eff_raw = '0;
            end
            eff_period = ((eff_raw != '0) && (eff_raw < MIN_PERIOD)) ? MIN_PERIOD : eff_raw;
        end

        always_ff @(posedge clock) begin
            if (!reset) begin
                state <= ST_IDLE;
            end else begin
                state <= state_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            case (state)
                ST_IDLE: begin
                    if (eff_period != '0) begin
                        state_nxt = (eff_dir != dir_q) ? ST_SETUP : ST_PULSE;
                    end
                end
                ST_SETUP: begin
                    // A direction flip during setup restarts the setup window.
                    if (eff_period == '0) begin
                        state_nxt = ST_IDLE;
                    end else if (eff_dir != dir_q) begin
                        state_nxt = ST_SETUP;
                    end else if (tmr == '0) begin
                        state_nxt = ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (tmr == '0) begin
                        state_nxt = ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (pcnt >= eff_period) begin
                        if (eff_period == '0) begin
                            state_nxt = ST_IDLE;
                        end else if (eff_dir != dir_q) begin
                            state_nxt = ST_SETUP;
                        end else begin
                            state_nxt = ST_PULSE;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        assign dir_load = (state_nxt == ST_SETUP) && (eff_dir != dir_q);
        assign rise     = (state_nxt == ST_PULSE) && (state != ST_PULSE);

        // tmr is a down-counter shared by SETUP and PULSE; pcnt counts up from the rising edge
        // so that a period change can be compared live against elapsed time.
        always_ff @(posedge clock) begin
            if (!reset) begin
                tmr   <= '0;
                pcnt  <= '0;
                dir_q <= 1'b0;
            end else begin
                if (dir_load) begin
                    dir_q <= eff_dir;
                    tmr   <= SETUP_LOAD;
                end else if (rise) begin
                    tmr   <= PULSE_LOAD;
                end else if (tmr != '0) begin
                    tmr   <= tmr - 1'b1;
                end

                if (rise) begin
                    pcnt <= SPEED_W'(1);
                end else if (((state == ST_PULSE) || (state == ST_GAP)) && (pcnt != '1)) begin
                    pcnt <= pcnt + 1'b1;
                end
            end
        end

        always_comb begin
            step_o = (state == ST_PULSE);
            busy_o = (state != ST_IDLE);
        end

        assign step_out[i] = step_o;
        assign busy[i]     = busy_o;
        assign dir_out[i]  = dir_q;

`ifdef POSITION_EN
        logic [POS_W-1:0] pos;

        always_ff @(posedge clock) begin
            if (!reset) begin
                pos <= '0;
            end else if (rise) begin
                pos <= dir_q ? (pos - 1'b1) : (pos + 1'b1);
            end
        end

        assign pos_out[i*POS_W +: POS_W] = pos;
`endif
    end

endmodule

// File: tb/tb_stepper_axis_ctrl.sv
// Directed bench for stepper_axis_ctrl with small timing parameters (pulse 4, setup 8, jog 40).
// Position checks are compiled in only when POSITION_EN is defined.
module tb_stepper_axis_ctrl;

    localparam int NA = 2;
    localparam int SW = 32;
    localparam int PW = 32;

    logic               clock = 1'b0;
    logic               reset;
    logic [NA-1:0]      load;
    logic [NA*SW-1:0]   speed_in;
    logic [NA-1:0]      dir_in;
    logic [NA-1:0]      jog_pos;
    logic [NA-1:0]      jog_neg;
    logic [NA-1:0]      step_out;
    logic [NA-1:0]      dir_out;
    logic [NA-1:0]      busy;
`ifdef POSITION_EN
    logic [NA*PW-1:0]   pos_out;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    stepper_axis_ctrl #(
        .NUM_AXES        (NA),
        .SPEED_W         (SW),
        .PULSE_CYCLES    (4),
        .DIR_SETUP_CYCLES(8),
        .JOG_PERIOD      (40),
        .POS_W           (PW)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .load    (load),
        .speed_in(speed_in),
        .dir_in  (dir_in),
        .jog_pos (jog_pos),
        .jog_neg (jog_neg),
        .step_out(step_out),
        .dir_out (dir_out),
        .busy    (busy)
`ifdef POSITION_EN
        ,
        .pos_out (pos_out)
`endif
    );

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) @(negedge clock);
    endtask

    // Returns clocks until the next step_out rising edge on axis ax, or -1 if none within limit.
    task automatic wait_rise(input int ax, input int limit, output int n);
        logic prev;
        prev = step_out[ax];
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clock);
            if (step_out[ax] && !prev) begin
                n = k;
                break;
            end
            prev = step_out[ax];
        end
    endtask

    task automatic load_axis(input int ax, input logic [SW-1:0] per, input logic d);
        speed_in[ax*SW +: SW] = per;
        dir_in[ax] = d;
        load[ax] = 1'b1;
        tick();
        load = '0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        load = '0; speed_in = '0; dir_in = '0; jog_pos = '0; jog_neg = '0;
        ticks(3);
        checks++; if (step_out !== 2'b00) begin failures++; $display("FAIL reset_step got=%b want=%b", step_out, 2'b00); end
        checks++; if (dir_out !== 2'b00) begin failures++; $display("FAIL reset_dir got=%b want=%b", dir_out, 2'b00); end
        checks++; if (busy !== 2'b00) begin failures++; $display("FAIL reset_busy got=%b want=%b", busy, 2'b00); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_axis();
        int n;
        int w;
        load_axis(0, 32'd20, 1'b0);
        checks++; if (busy !== 2'b00) begin failures++; $display("FAIL lat_busy_k got=%b want=%b", busy, 2'b00); end
        tick();
        checks++; if (step_out !== 2'b01) begin failures++; $display("FAIL lat_step_k1 got=%b want=%b", step_out, 2'b01); end
        checks++; if (busy !== 2'b01) begin failures++; $display("FAIL lat_busy_k1 got=%b want=%b", busy, 2'b01); end
        w = 0;
        while (step_out[0] && w < 50) begin w++; tick(); end
        checks++; if (w !== 4) begin failures++; $display("FAIL pulse_width got=%0d want=%0d", w, 4); end
        wait_rise(0, 100, n);
        checks++; if (n !== 16) begin failures++; $display("FAIL period_rest got=%0d want=%0d", n, 16); end
        wait_rise(0, 100, n);
        checks++; if (n !== 20) begin failures++; $display("FAIL period_20 got=%0d want=%0d", n, 20); end
        checks++; if (dir_out[0] !== 1'b0) begin failures++; $display("FAIL run_dir0 got=%b want=%b", dir_out[0], 1'b0); end
        checks++; if (busy[1] !== 1'b0) begin failures++; $display("FAIL axis1_idle got=%b want=%b", busy[1], 1'b0); end
`ifdef POSITION_EN
        checks++; if (pos_out[31:0] !== 32'd3) begin failures++; $display("FAIL pos_up got=%0d want=%0d", pos_out[31:0], 3); end
`endif
    endtask

    task automatic test_dir_change();
        int n;
        load_axis(0, 32'd20, 1'b1);
        ticks(18);
        checks++; if (dir_out[0] !== 1'b0) begin failures++; $display("FAIL dir_hold_c19 got=%b want=%b", dir_out[0], 1'b0); end
        tick();
        checks++; if (dir_out[0] !== 1'b1) begin failures++; $display("FAIL dir_flip_c20 got=%b want=%b", dir_out[0], 1'b1); end
        checks++; if (step_out[0] !== 1'b0) begin failures++; $display("FAIL setup_step got=%b want=%b", step_out[0], 1'b0); end
        wait_rise(0, 50, n);
        checks++; if (n !== 8) begin failures++; $display("FAIL dir_setup got=%0d want=%0d", n, 8); end
        wait_rise(0, 50, n);
        checks++; if (n !== 20) begin failures++; $display("FAIL period_neg got=%0d want=%0d", n, 20); end
`ifdef POSITION_EN
        checks++; if (pos_out[31:0] !== 32'd1) begin failures++; $display("FAIL pos_down got=%0d want=%0d", pos_out[31:0], 1); end
`endif
    endtask

    task automatic test_clamp();
        int n;
        load_axis(0, 32'd3, 1'b1);
        wait_rise(0, 50, n);
        checks++; if (n !== 7) begin failures++; $display("FAIL clamp_first got=%0d want=%0d", n, 7); end
        wait_rise(0, 50, n);
        checks++; if (n !== 8) begin failures++; $display("FAIL clamp_period got=%0d want=%0d", n, 8); end
        load_axis(0, 32'hFFFF_FFFF, 1'b1);
        wait_rise(0, 200, n);
        checks++; if (n !== -1) begin failures++; $display("FAIL long_gap_rise got=%0d want=%0d", n, -1); end
        checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL long_gap_busy got=%b want=%b", busy[0], 1'b1); end
`ifdef POSITION_EN
        checks++; if (pos_out[31:0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL pos_wrap got=%h want=%h", pos_out[31:0], 32'hFFFF_FFFF); end
`endif
    endtask

    task automatic test_stop_in_gap();
        int n;
        load_axis(0, 32'd0, 1'b0);
        checks++; if (busy[0] !== 1'b1) begin failures++; $display("FAIL stop_busy_k got=%b want=%b", busy[0], 1'b1); end
        tick();
        checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL stop_busy_k1 got=%b want=%b", busy[0], 1'b0); end
        checks++; if (dir_out[0] !== 1'b1) begin failures++; $display("FAIL stop_dir_held got=%b want=%b", dir_out[0], 1'b1); end
        wait_rise(0, 60, n);
        checks++; if (n !== -1) begin failures++; $display("FAIL stop_no_rise got=%0d want=%0d", n, -1); end
    endtask

    task automatic test_jog();
        int n;
        jog_pos[1] = 1'b1;
        tick();
        checks++; if (step_out[1] !== 1'b1) begin failures++; $display("FAIL jog_first got=%b want=%b", step_out[1], 1'b1); end
        wait_rise(1, 100, n);
        checks++; if (n !== 40) begin failures++; $display("FAIL jog_period got=%0d want=%0d", n, 40); end
        checks++; if (dir_out[1] !== 1'b0) begin failures++; $display("FAIL jog_dir got=%b want=%b", dir_out[1], 1'b0); end
        tick();
        jog_neg[1] = 1'b1;
        ticks(2);
        checks++; if (step_out[1] !== 1'b1) begin failures++; $display("FAIL jog_both_pulse got=%b want=%b", step_out[1], 1'b1); end
        tick();
        checks++; if ({step_out[1], busy[1]} !== 2'b01) begin failures++; $display("FAIL jog_both_gap got=%b want=%b", {step_out[1], busy[1]}, 2'b01); end
        tick();
        checks++; if (busy[1] !== 1'b0) begin failures++; $display("FAIL jog_both_idle got=%b want=%b", busy[1], 1'b0); end
        jog_pos[1] = 1'b0;
        tick();
        checks++; if (dir_out[1] !== 1'b1) begin failures++; $display("FAIL jog_neg_dir got=%b want=%b", dir_out[1], 1'b1); end
        wait_rise(1, 50, n);
        checks++; if (n !== 8) begin failures++; $display("FAIL jog_neg_setup got=%0d want=%0d", n, 8); end
        jog_neg[1] = 1'b0;
        ticks(6);
        checks++; if (busy[1] !== 1'b0) begin failures++; $display("FAIL jog_release got=%b want=%b", busy[1], 1'b0); end
`ifdef POSITION_EN
        checks++; if (pos_out[63:32] !== 32'd1) begin failures++; $display("FAIL jog_pos_cnt got=%0d want=%0d", pos_out[63:32], 1); end
`endif
    endtask

    task automatic test_back_to_back();
        speed_in = {32'd12, 32'd10};
        dir_in = 2'b11;
        load = 2'b11;
        tick();
        load = '0;
        tick();
        checks++; if (step_out !== 2'b11) begin failures++; $display("FAIL dual_start got=%b want=%b", step_out, 2'b11); end
        ticks(9);
        checks++; if (step_out !== 2'b00) begin failures++; $display("FAIL dual_c9 got=%b want=%b", step_out, 2'b00); end
        tick();
        checks++; if (step_out !== 2'b01) begin failures++; $display("FAIL dual_c10 got=%b want=%b", step_out, 2'b01); end
        ticks(2);
        checks++; if (step_out !== 2'b11) begin failures++; $display("FAIL dual_c12 got=%b want=%b", step_out, 2'b11); end
        speed_in = '0;
        load = 2'b11;
        tick();
        load = '0;
        ticks(10);
        checks++; if (busy !== 2'b00) begin failures++; $display("FAIL dual_stop got=%b want=%b", busy, 2'b00); end
    endtask

    task automatic test_reset_mid_pulse();
        load_axis(0, 32'd20, 1'b1);
        tick();
        checks++; if (step_out[0] !== 1'b1) begin failures++; $display("FAIL rst_pre_pulse got=%b want=%b", step_out[0], 1'b1); end
        tick();
        reset = 1'b0;
        tick();
        checks++; if ({step_out, dir_out, busy} !== 6'b0) begin failures++; $display("FAIL rst_cut got=%b want=%b", {step_out, dir_out, busy}, 6'b0); end
`ifdef POSITION_EN
        checks++; if (pos_out !== '0) begin failures++; $display("FAIL rst_pos got=%h want=0", pos_out); end
`endif
        reset = 1'b1;
        ticks(30);
        checks++; if ({step_out, busy} !== 4'b0) begin failures++; $display("FAIL rst_regs_cleared got=%b want=%b", {step_out, busy}, 4'b0); end
    endtask

    initial begin
        test_reset();
        test_single_axis();
        test_dir_change();
        test_clamp();
        test_stop_in_gap();
        test_jog();
        test_back_to_back();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
